// File: rtl/sdr_16_arb.sv
// sdr_16_arb: four-port command arbiter with refresh scheduling for an SDR
// SDRAM controller. It grants one ingress port at a time to the SDRAM FSM,
// issues refresh requests from a free-running refresh timer, and counts
// refreshes that are still owed.
//
// Ports:
//   sdram_clk    - sole clock, all state on the rising edge
//   sdram_rst_n  - asynchronous active-low reset
//   req[3:0]     - per-port pending command (port FIFO not empty)
//   state_idle   - SDRAM FSM is idle
//   cmd_aref     - SDRAM FSM issued auto-refresh (one-cycle pulse)
//   gnt[3:0]     - one-hot grant, all-zero = none
//   gnt_sel[1:0] - binary index of granted port, holds when gnt == 0
//   refresh_req  - refresh request to SDRAM FSM
//   rfr_pend[2:0]- number of owed refreshes (saturates at 7)
//   rfr_miss     - sticky: owed-refresh count overflowed
//
// Build option: define SDR_16_ARB_PRIO0_EN to give port 0 fixed top priority,
// with ports 1-3 round-robin among themselves.
module sdr_16_arb #(
  parameter int unsigned RFR_PERIOD = 390,
  parameter int unsigned RFR_CNT_W  = 10
) (
  input  logic       sdram_clk,
  input  logic       sdram_rst_n,
  input  logic [3:0] req,
  input  logic       state_idle,
  input  logic       cmd_aref,
  output logic [3:0] gnt,
  output logic [1:0] gnt_sel,
  output logic       refresh_req,
  output logic [2:0] rfr_pend,
  output logic       rfr_miss
);

  localparam int unsigned NPORT  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned PEND_W = 3;
  localparam logic [RFR_CNT_W-1:0] RELOAD   = RFR_CNT_W'(RFR_PERIOD - 1);
  localparam logic [PEND_W-1:0]    PEND_MAX = PEND_W'(7);

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT, ARB_BUSY, ARB_RFR} arb_state_e;

  arb_state_e           state_q, state_d;
  logic [NPORT-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]     gnt_sel_q, gnt_sel_d;
  logic                 refresh_req_q, refresh_req_d;
  logic                 aref_seen_q, aref_seen_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [RFR_CNT_W-1:0] timer_q, timer_d;
  logic [PEND_W-1:0]    rfr_pend_q, rfr_pend_d;
  logic                 rfr_miss_q, rfr_miss_d;

  logic                 win_vld_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic [IDX_W-1:0]     cand_c;
  logic                 tick_c;
  logic                 dec_c;

  // Round-robin winner: first requester at or after rr_ptr, modulo 4.
  // Scanning offsets downward lets the smallest offset overwrite last.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = rr_ptr_q;
    cand_c    = rr_ptr_q;
    for (int k = NPORT - 1; k >= 0; k--) begin
      cand_c = rr_ptr_q + IDX_W'(k);
`ifdef SDR_16_ARB_PRIO0_EN
      if (req[cand_c] && (cand_c != '0)) begin
`else
      if (req[cand_c]) begin
`endif
        win_vld_c = 1'b1;
        win_idx_c = cand_c;
      end
    end
`ifdef SDR_16_ARB_PRIO0_EN
    // Port 0 overrides the rotation among ports 1-3.
    if (req[0]) begin
      win_vld_c = 1'b1;
      win_idx_c = '0;
    end
`endif
  end

  // Next-state, grant/refresh outputs and refresh bookkeeping.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gnt_sel_d     = gnt_sel_q;
    refresh_req_d = refresh_req_q;
    aref_seen_d   = aref_seen_q;
    rr_ptr_d      = rr_ptr_q;
    rfr_pend_d    = rfr_pend_q;
    rfr_miss_d    = rfr_miss_q;

    tick_c  = (timer_q == '0);
    timer_d = tick_c ? RELOAD : (timer_q - RFR_CNT_W'(1));
    // refresh_req is only ever high in ARB_RFR before the aref is seen.
    dec_c   = refresh_req_q && cmd_aref;

    unique case (state_q)
      ARB_IDLE: begin
        gnt_d         = '0;
        refresh_req_d = 1'b0;
        if (state_idle && (rfr_pend_q != '0)) begin
          state_d       = ARB_RFR;
          refresh_req_d = 1'b1;
          aref_seen_d   = 1'b0;
        end else if (state_idle && win_vld_c) begin
          state_d   = ARB_GNT;
          gnt_d     = NPORT'(1) << win_idx_c;
          gnt_sel_d = win_idx_c;
        end
      end
      ARB_GNT: begin
        if (!state_idle) begin
          state_d = ARB_BUSY;
        end else if (!req[gnt_sel_q]) begin
          // Request withdrawn before the FSM took it: pointer stays put.
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end
      end
      ARB_BUSY: begin
        if (state_idle) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
`ifdef SDR_16_ARB_PRIO0_EN
          if (gnt_sel_q != '0) rr_ptr_d = gnt_sel_q + IDX_W'(1);
`else
          rr_ptr_d = gnt_sel_q + IDX_W'(1);
`endif
        end
      end
      ARB_RFR: begin
        if (!aref_seen_q) begin
          if (cmd_aref) begin
            refresh_req_d = 1'b0;
            aref_seen_d   = 1'b1;
          end
        end else if (state_idle) begin
          state_d     = ARB_IDLE;
          aref_seen_d = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Owed-refresh counter; a simultaneous tick and aref cancel out.
    if (tick_c && !dec_c) begin
      if (rfr_pend_q == PEND_MAX) rfr_miss_d = 1'b1;
      else                        rfr_pend_d = rfr_pend_q + PEND_W'(1);
    end else if (dec_c && !tick_c && (rfr_pend_q != '0)) begin
      rfr_pend_d = rfr_pend_q - PEND_W'(1);
    end
  end

  // State register.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q       <= ARB_IDLE;
      gnt_q         <= '0;
      gnt_sel_q     <= '0;
      refresh_req_q <= 1'b0;
      aref_seen_q   <= 1'b0;
      rr_ptr_q      <= '0;
      timer_q       <= RELOAD;
      rfr_pend_q    <= '0;
      rfr_miss_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      gnt_sel_q     <= gnt_sel_d;
      refresh_req_q <= refresh_req_d;
      aref_seen_q   <= aref_seen_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
      rfr_pend_q    <= rfr_pend_d;
      rfr_miss_q    <= rfr_miss_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_sel     = gnt_sel_q;
  assign refresh_req = refresh_req_q;
  assign rfr_pend    = rfr_pend_q;
  assign rfr_miss    = rfr_miss_q;

endmodule

// File: tb/tb_sdr_16_arb.sv
// Directed testbench for sdr_16_arb with RFR_PERIOD = 16.
module tb_sdr_16_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       state_idle;
  logic       cmd_aref;
  logic [3:0] gnt;
  logic [1:0] gnt_sel;
  logic       refresh_req;
  logic [2:0] rfr_pend;
  logic       rfr_miss;

  int checks = 0;
  int errors = 0;

  sdr_16_arb #(.RFR_PERIOD(16), .RFR_CNT_W(5)) dut (
    .sdram_clk  (clk),
    .sdram_rst_n(rst_n),
    .req        (req),
    .state_idle (state_idle),
    .cmd_aref   (cmd_aref),
    .gnt        (gnt),
    .gnt_sel    (gnt_sel),
    .refresh_req(refresh_req),
    .rfr_pend   (rfr_pend),
    .rfr_miss   (rfr_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released just after an edge; the next edge is "edge 1".
  task automatic do_reset();
    rst_n      = 1'b0;
    req        = '0;
    state_idle = 1'b1;
    cmd_aref   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Called right after refresh_req is seen; aref two cycles later, back in idle after.
  task automatic serve_refresh();
    step();
    cmd_aref = 1'b1;
    step();
    cmd_aref = 1'b0;
    step();
  endtask

  // Steps until a grant appears, serving any refresh on the way.
  task automatic wait_gnt(output logic [3:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (refresh_req === 1'b1) begin
        serve_refresh();
      end else if (gnt !== 4'b0000) begin
        g  = gnt;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; state_idle = 1'b1; cmd_aref = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0 || gnt_sel !== 2'b0 || refresh_req !== 1'b0 ||
        rfr_pend !== 3'd0 || rfr_miss !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b sel=%0d rreq=%b pend=%0d miss=%b, required all zero",
               gnt, gnt_sel, refresh_req, rfr_pend, rfr_miss);
    end
    rst_n = 1'b1;
    cmd_aref = 1'b1;
    step();
    cmd_aref = 1'b0;
    step();
    checks++;
    if (rfr_pend !== 3'd0 || refresh_req !== 1'b0) begin
      errors++;
      $display("FAIL aref_ignored_idle: pend=%0d rreq=%b, required 0 0", rfr_pend, refresh_req);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [3:0] g;
    bit ok;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    step();
    g = gnt;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rr_latency: gnt=%b, required 0001", gnt);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_gnt(g, ok);
        checks++;
        if (!ok || g !== exp_g[i]) begin
          errors++;
          $display("FAIL rr_seq%0d: gnt=%b ok=%0d, required %b", i, g, ok, exp_g[i]);
        end
      end
      checks++;
      if (gnt_sel !== 2'(i % 4)) begin
        errors++;
        $display("FAIL rr_sel%0d: gnt_sel=%0d, required %0d", i, gnt_sel, i % 4);
      end
      state_idle = 1'b0;
      repeat (5) step();
      checks++;
      if (gnt !== exp_g[i] || refresh_req !== 1'b0) begin
        errors++;
        $display("FAIL rr_hold%0d: gnt=%b rreq=%b, required %b 0", i, gnt, refresh_req, exp_g[i]);
      end
      state_idle = 1'b1;
      step();
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_release%0d: gnt=%b, required 0000", i, gnt);
      end
    end
    req = '0;
  endtask

  task automatic test_refresh();
    int n;
    int m;
    do_reset();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (refresh_req === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != 17 || rfr_pend !== 3'd1 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL rfr_first: edge=%0d pend=%0d gnt=%b, required 17 1 0000", n, rfr_pend, gnt);
    end
    step();
    checks++;
    if (refresh_req !== 1'b1) begin
      errors++;
      $display("FAIL rfr_hold: rreq=%b, required 1", refresh_req);
    end
    cmd_aref = 1'b1;
    step();
    cmd_aref = 1'b0;
    checks++;
    if (refresh_req !== 1'b0 || rfr_pend !== 3'd0) begin
      errors++;
      $display("FAIL rfr_ack: rreq=%b pend=%0d, required 0 0", refresh_req, rfr_pend);
    end
    m = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (refresh_req === 1'b1) begin m = i; break; end
    end
    checks++;
    if (m != 14 || rfr_pend !== 3'd1) begin
      errors++;
      $display("FAIL rfr_period: next at +%0d pend=%0d, required +14 1", m, rfr_pend);
    end
    serve_refresh();
  endtask

  task automatic test_busy_refresh();
    do_reset();
    req = 4'b0010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL busy_gnt: gnt=%b, required 0010", gnt);
    end
    state_idle = 1'b0;
    repeat (17) step();
    checks++;
    if (gnt !== 4'b0010 || refresh_req !== 1'b0 || rfr_pend !== 3'd1) begin
      errors++;
      $display("FAIL busy_no_preempt: gnt=%b rreq=%b pend=%0d, required 0010 0 1",
               gnt, refresh_req, rfr_pend);
    end
    cmd_aref = 1'b1;
    step();
    cmd_aref = 1'b0;
    checks++;
    if (rfr_pend !== 3'd1) begin
      errors++;
      $display("FAIL busy_aref_ignored: pend=%0d, required 1", rfr_pend);
    end
    step();
    state_idle = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0000 || refresh_req !== 1'b0) begin
      errors++;
      $display("FAIL busy_release: gnt=%b rreq=%b, required 0000 0", gnt, refresh_req);
    end
    step();
    checks++;
    if (refresh_req !== 1'b1 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL busy_rfr_first: rreq=%b gnt=%b, required 1 0000", refresh_req, gnt);
    end
    serve_refresh();
    req = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100 || gnt_sel !== 2'd2) begin
      errors++;
      $display("FAIL wd_gnt: gnt=%b sel=%0d, required 0100 2", gnt, gnt_sel);
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000 || gnt_sel !== 2'd2) begin
      errors++;
      $display("FAIL wd_drop: gnt=%b sel=%0d, required 0000 2", gnt, gnt_sel);
    end
    req = 4'b1100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL wd_regrant: gnt=%b, required 0100", gnt);
    end
    req = '0;
  endtask

  task automatic test_saturate();
    do_reset();
    state_idle = 1'b0;
    repeat (112) step();
    checks++;
    if (rfr_pend !== 3'd7 || rfr_miss !== 1'b0) begin
      errors++;
      $display("FAIL sat_seven: pend=%0d miss=%b, required 7 0", rfr_pend, rfr_miss);
    end
    repeat (16) step();
    checks++;
    if (rfr_pend !== 3'd7 || rfr_miss !== 1'b1) begin
      errors++;
      $display("FAIL sat_miss: pend=%0d miss=%b, required 7 1", rfr_pend, rfr_miss);
    end
    state_idle = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if (refresh_req !== 1'b1 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL sat_b2b%0d: rreq=%b gnt=%b, required 1 0000", k, refresh_req, gnt);
      end
      serve_refresh();
    end
    checks++;
    if (rfr_pend !== 3'd1 || rfr_miss !== 1'b1) begin
      errors++;
      $display("FAIL sat_after: pend=%0d miss=%b, required 1 1", rfr_pend, rfr_miss);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1000;
    step();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL ar_gnt: gnt=%b, required 1000", gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_sel !== 2'd0) begin
      errors++;
      $display("FAIL ar_immediate: gnt=%b sel=%0d, required 0000 0", gnt, gnt_sel);
    end
    repeat (3) step();
    checks++;
    if (gnt !== 4'b0000 || refresh_req !== 1'b0) begin
      errors++;
      $display("FAIL ar_held: gnt=%b rreq=%b, required 0000 0", gnt, refresh_req);
    end
    rst_n = 1'b1;
    req = '0;
  endtask

`ifdef SDR_16_ARB_PRIO0_EN
  task automatic test_prio0();
    logic [3:0] exp_g [6];
    logic [3:0] g;
    bit ok;
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req = (i < 3) ? 4'b1111 : 4'b1110;
      wait_gnt(g, ok);
      checks++;
      if (!ok || g !== exp_g[i]) begin
        errors++;
        $display("FAIL prio_seq%0d: gnt=%b ok=%0d, required %b", i, g, ok, exp_g[i]);
      end
      state_idle = 1'b0;
      repeat (2) step();
      state_idle = 1'b1;
      step();
    end
    req = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifndef SDR_16_ARB_PRIO0_EN
    test_round_robin();
`else
    test_prio0();
`endif
    test_refresh();
    test_busy_refresh();
    test_withdraw();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
